z80_bus_responder: RTL

Z80_BUS_RESPONDER -- requirements
Module: z80_bus_responder

---
 rtl/z80_bus_pkg.sv | 17 +
 rtl/z80_int_gen.sv | 47 ++++
 rtl/z80_bus_responder.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/z80_bus_pkg.sv
// Shared types and default parameter values for the Z80 bus responder.
package z80_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } wait_state_t;

    localparam int unsigned DEF_ADDR_W      = 12;
    localparam int unsigned DEF_ROM_SIZE    = 1024;
    localparam int unsigned DEF_WAIT_STATES = 0;
    localparam int unsigned DEF_INT_PERIOD  = 0;
    localparam logic [7:0]  DEF_INT_VECTOR  = 8'hFF;
    localparam logic [7:0]  DEF_IO_OUT_PORT = 8'h00;

endpackage

// File: rtl/z80_int_gen.sv
// Periodic maskable-interrupt request generator, cleared by an int-ack cycle.
module z80_int_gen
    import z80_bus_pkg::*;
#(
    parameter int unsigned INT_PERIOD = DEF_INT_PERIOD
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_ack,
    output logic o_int_n
);

    generate
        if (INT_PERIOD == 0) begin : g_off
            logic w_unused;
            assign w_unused = &{1'b0, i_clk, i_rst_n, i_ack};
            assign o_int_n  = 1'b1;
        end else begin : g_on
            localparam int unsigned CW = (INT_PERIOD > 1) ? $clog2(INT_PERIOD) : 1;
            localparam logic [CW-1:0] LAST = CW'(INT_PERIOD - 1);

            logic [CW-1:0] r_cnt;
            logic          r_int_n;
            logic          w_wrap;

            assign w_wrap = (r_cnt == LAST);

            // Counter free-runs; a wrap while a request is pending is simply absorbed.
            always_ff @(posedge i_clk) begin
                if (!i_rst_n) begin
                    r_cnt   <= '0;
                    r_int_n <= 1'b1;
                end else begin
                    r_cnt <= w_wrap ? '0 : r_cnt + CW'(1);
                    if (!r_int_n && i_ack) begin
                        r_int_n <= 1'b1;
                    end else if (w_wrap) begin
                        r_int_n <= 1'b0;
                    end
                end
            end

            assign o_int_n = r_int_n;
        end
    endgenerate

endmodule

// File: rtl/z80_bus_responder.sv
// Z80 bus slave: byte memory with write-protected ROM region, I/O port, wait FSM, interrupts.
module z80_bus_responder
    import z80_bus_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned ROM_SIZE    = DEF_ROM_SIZE,
    parameter int unsigned WAIT_STATES = DEF_WAIT_STATES,
    parameter int unsigned INT_PERIOD  = DEF_INT_PERIOD,
    parameter logic [7:0]  INT_VECTOR  = DEF_INT_VECTOR,
    parameter logic [7:0]  IO_OUT_PORT = DEF_IO_OUT_PORT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              m1_n,
    input  logic              mreq_n,
    input  logic              iorq_n,
    input  logic              rd_n,
    input  logic              wr_n,
    input  logic              rfsh_n,
    input  logic [15:0]       A,
    input  logic [7:0]        dout,
    output logic [7:0]        di,
    output logic              wait_n,
    output logic              int_n,
    input  logic [7:0]        io_in,
    output logic [7:0]        io_out,
    output logic              io_out_stb,
    output logic              rom_viol,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [7:0]        load_data
);

    localparam logic [3:0] WS_LAST = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    logic [7:0]        r_mem [0:(1 << ADDR_W) - 1];
    logic              r_wr_n_q, r_mreq_n_q, r_iorq_n_q;
    logic              r_rom_viol, r_io_out_stb, r_wait_n;
    logic [7:0]        r_io_out;
    logic [3:0]        r_ws_cnt, w_ws_cnt_nxt;
    wait_state_t       r_state, w_state_nxt;
    logic [ADDR_W-1:0] w_addr;
    logic              w_wr_edge, w_mem_wr, w_rom_hit, w_io_wr, w_acc_start, w_int_ack;
    logic [7:0]        w_di;
    logic              w_unused;

    assign w_unused    = &{1'b0, A};
    assign w_addr      = A[ADDR_W-1:0];
    assign w_int_ack   = !m1_n && !iorq_n;
    assign w_wr_edge   = !wr_n && r_wr_n_q;
    assign w_rom_hit   = 32'(w_addr) < ROM_SIZE;
    // Preload owns the single write port, so a coincident CPU write is dropped entirely.
    assign w_mem_wr    = reset_n && !load_en && !mreq_n && rfsh_n && w_wr_edge;
    assign w_io_wr     = reset_n && !iorq_n && m1_n && w_wr_edge && (A[7:0] == IO_OUT_PORT);
    assign w_acc_start = rfsh_n && ((!mreq_n && r_mreq_n_q) || (!iorq_n && r_iorq_n_q));

    always_ff @(posedge clk) begin
        if (load_en) begin
            r_mem[load_addr] <= load_data;
        end else if (w_mem_wr && !w_rom_hit) begin
            r_mem[w_addr] <= dout;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_n_q     <= 1'b1;
            r_mreq_n_q   <= 1'b1;
            r_iorq_n_q   <= 1'b1;
            r_rom_viol   <= 1'b0;
            r_io_out     <= '0;
            r_io_out_stb <= 1'b0;
        end else begin
            r_wr_n_q     <= wr_n;
            r_mreq_n_q   <= mreq_n;
            r_iorq_n_q   <= iorq_n;
            r_rom_viol   <= w_mem_wr && w_rom_hit;
            r_io_out_stb <= w_io_wr;
            if (w_io_wr) begin
                r_io_out <= dout;
            end
        end
    end

    always_comb begin
        w_di = 8'hFF;
        if (w_int_ack) begin
            w_di = INT_VECTOR;
        end else if (!iorq_n && !rd_n) begin
            w_di = io_in;
        end else if (!rd_n) begin
            w_di = r_mem[w_addr];
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_ws_cnt_nxt = r_ws_cnt;
        unique case (r_state)
            ST_IDLE: begin
                if (w_acc_start && (WAIT_STATES != 0)) begin
                    w_state_nxt  = ST_WAIT;
                    w_ws_cnt_nxt = '0;
                end
            end
            ST_WAIT: begin
                if (r_ws_cnt == WS_LAST) begin
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_ws_cnt_nxt = r_ws_cnt + 4'd1;
                end
            end
            ST_HOLD: begin
                if (mreq_n && iorq_n) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // wait_n is registered from the next state so it is low exactly while in WAIT.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_ws_cnt <= '0;
            r_wait_n <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_ws_cnt <= w_ws_cnt_nxt;
            r_wait_n <= (w_state_nxt != ST_WAIT);
        end
    end

    z80_int_gen #(
        .INT_PERIOD(INT_PERIOD)
    ) u_int_gen (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_ack   (w_int_ack),
        .o_int_n (int_n)
    );

    assign di         = w_di;
    assign wait_n     = r_wait_n;
    assign io_out     = r_io_out;
    assign io_out_stb = r_io_out_stb;
    assign rom_viol   = r_rom_viol;

endmodule
